ad9826_init_seq: RTL and testbench

Register-sequencer stage directly upstream of the AD9826 serial configuration port driver. It holds a shadow copy of the eight AD9826 configuration registers and, on `start`, writes them in address order through the driver's `ad_config_in`/`toggle` handshake. With verify enabled, it reads each register back and compares the result. It reports completion, or the first failing address, to the control logic.

---
 rtl/ad9826_pkg.sv | 59 +++++
 rtl/ad9826_shadow_regs.sv | 33 +++
 rtl/ad9826_init_seq.sv | 202 ++++++++++++++++++++
 tb/tb_ad9826_init_seq.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad9826_pkg.sv
// Shared types and constants for the AD9826 configuration sequencer:
// FSM states, cfg_word layout, error codes and register address names.
package ad9826_pkg;

  localparam int unsigned AddrW = 3;
  localparam int unsigned DataW = 9;
  localparam int unsigned CfgW  = 16;

  // cfg_word layout: {rw, addr[2:0], 3'b000, data[8:0]}
  localparam int unsigned CfgRwBit   = 15;
  localparam int unsigned CfgAddrMsb = 14;
  localparam int unsigned CfgAddrLsb = 12;
  localparam int unsigned CfgDataMsb = 8;

  localparam logic CfgWrite = 1'b0;
  localparam logic CfgRead  = 1'b1;

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StReq,
    StXfer,
    StRload,
    StRreq,
    StRxfer,
    StCheck,
    StNext,
    StDone,
    StErr
  } seq_state_e;

  typedef enum logic [1:0] {
    ErrNone        = 2'b00,
    ErrReqTimeout  = 2'b01,
    ErrXferTimeout = 2'b10,
    ErrVerify      = 2'b11
  } err_code_e;

  localparam logic [AddrW-1:0] AddrConfig = 3'd0;
  localparam logic [AddrW-1:0] AddrMux    = 3'd1;
  localparam logic [AddrW-1:0] AddrPgaR   = 3'd2;
  localparam logic [AddrW-1:0] AddrPgaG   = 3'd3;
  localparam logic [AddrW-1:0] AddrPgaB   = 3'd4;
  localparam logic [AddrW-1:0] AddrOffsR  = 3'd5;
  localparam logic [AddrW-1:0] AddrOffsG  = 3'd6;
  localparam logic [AddrW-1:0] AddrOffsB  = 3'd7;

  function automatic logic [CfgW-1:0] cfg_pack(input logic rw,
                                               input logic [AddrW-1:0] addr,
                                               input logic [DataW-1:0] data);
    logic [CfgW-1:0] w;
    w = '0;
    w[CfgRwBit] = rw;
    w[CfgAddrMsb:CfgAddrLsb] = addr;
    w[CfgDataMsb:0] = data;
    return w;
  endfunction

endpackage

// File: rtl/ad9826_shadow_regs.sv
// Shadow copy of the eight AD9826 configuration registers:
// one synchronous write port, one asynchronous read port.
module ad9826_shadow_regs
  import ad9826_pkg::*;
#(
  parameter logic [DataW-1:0] REG0_RESET = 9'h000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AddrW-1:0] wr_addr,
  input  logic [DataW-1:0] wr_data,
  input  logic [AddrW-1:0] rd_addr,
  output logic [DataW-1:0] rd_data
);

  localparam int unsigned Depth = 1 << AddrW;

  logic [DataW-1:0] regs_q [Depth];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= (i == 0) ? REG0_RESET : '0;
      end
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = regs_q[rd_addr];

endmodule

// File: rtl/ad9826_init_seq.sv
// Writes the shadow registers to the AD9826 through the serial-port driver handshake,
// optionally reading each one back, and reports completion or the first failing address.
module ad9826_init_seq
  import ad9826_pkg::*;
#(
  parameter int unsigned      NUM_REGS     = 8,
  parameter int unsigned      REQ_TIMEOUT  = 64,
  parameter int unsigned      XFER_TIMEOUT = 1024,
  parameter logic [DataW-1:0] REG0_RESET   = 9'h000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             verify,
  input  logic             reg_wr_en,
  input  logic [AddrW-1:0] reg_wr_addr,
  input  logic [DataW-1:0] reg_wr_data,
  output logic [CfgW-1:0]  cfg_word,
  output logic             cfg_toggle,
  input  logic             cfg_sload,
  input  logic [CfgW-1:0]  cfg_readback,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [AddrW-1:0] err_addr,
  output logic [1:0]       err_code
);

  // REQ counts from the toggle rise (one cycle after entry); XFER counts from entry.
  localparam logic [9:0]       ReqLoad  = 10'(REQ_TIMEOUT);
  localparam logic [9:0]       XferLoad = 10'(XFER_TIMEOUT - 1);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(NUM_REGS - 1);

  seq_state_e       state_q, state_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic             verify_q, verify_d;
  logic [CfgW-1:0]  word_q, word_d;
  logic [DataW-1:0] data_q, data_d;
  logic             toggle_q, toggle_d;
  logic [9:0]       tmr_q, tmr_d;
  logic             error_q, error_d;
  logic [AddrW-1:0] err_addr_q, err_addr_d;
  err_code_e        err_code_q, err_code_d;

  logic             sload_meta_q, sload_s;
  logic [1:0]       prime_q;
  logic             sync_ok;
  logic [DataW-1:0] shadow_rd;
  logic             tmr_zero;
  logic             unused_readback;

  ad9826_shadow_regs #(
    .REG0_RESET (REG0_RESET)
  ) u_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (reg_wr_en),
    .wr_addr (reg_wr_addr),
    .wr_data (reg_wr_data),
    .rd_addr (addr_q),
    .rd_data (shadow_rd)
  );

  // sload_s only counts as observed once two post-reset samples have filled the synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sload_meta_q <= 1'b1;
      sload_s      <= 1'b1;
      prime_q      <= 2'b00;
    end else begin
      sload_meta_q <= cfg_sload;
      sload_s      <= sload_meta_q;
      prime_q      <= {prime_q[0], 1'b1};
    end
  end

  assign sync_ok  = prime_q[1];
  assign busy     = (state_q != StIdle) | !sload_s | !sync_ok;
  assign tmr_zero = (tmr_q == '0);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    verify_d   = verify_q;
    word_d     = word_q;
    data_d     = data_q;
    toggle_d   = 1'b0;
    tmr_d      = tmr_q;
    error_d    = error_q;
    err_addr_d = err_addr_q;
    err_code_d = err_code_q;

    unique case (state_q)
      StIdle: begin
        if (start && !busy) begin
          state_d  = StLoad;
          addr_d   = '0;
          error_d  = 1'b0;
          verify_d = verify;
        end
      end
      StLoad: begin
        word_d  = cfg_pack(CfgWrite, addr_q, shadow_rd);
        data_d  = shadow_rd;
        tmr_d   = ReqLoad;
        state_d = StReq;
      end
      StReq, StRreq: begin
        if (!sload_s) begin
          state_d = (state_q == StReq) ? StXfer : StRxfer;
          tmr_d   = XferLoad;
        end else if (tmr_zero) begin
          state_d    = StErr;
          error_d    = 1'b1;
          err_addr_d = addr_q;
          err_code_d = ErrReqTimeout;
        end else begin
          toggle_d = 1'b1;
          tmr_d    = tmr_q - 10'd1;
        end
      end
      StXfer, StRxfer: begin
        if (sload_s) begin
          if (state_q == StRxfer) begin
            state_d = StCheck;
          end else begin
            state_d = verify_q ? StRload : StNext;
          end
        end else if (tmr_zero) begin
          state_d    = StErr;
          error_d    = 1'b1;
          err_addr_d = addr_q;
          err_code_d = ErrXferTimeout;
        end else begin
          tmr_d = tmr_q - 10'd1;
        end
      end
      StRload: begin
        word_d  = cfg_pack(CfgRead, addr_q, '0);
        tmr_d   = ReqLoad;
        state_d = StRreq;
      end
      StCheck: begin
        // data_q was captured in LOAD, so late shadow writes cannot affect this compare.
        if (cfg_readback[CfgDataMsb:0] != data_q) begin
          state_d    = StErr;
          error_d    = 1'b1;
          err_addr_d = addr_q;
          err_code_d = ErrVerify;
        end else begin
          state_d = StNext;
        end
      end
      StNext: begin
        if (addr_q == LastAddr) begin
          state_d = StDone;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = StLoad;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      verify_q   <= 1'b0;
      word_q     <= '0;
      data_q     <= '0;
      toggle_q   <= 1'b0;
      tmr_q      <= '0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
      err_code_q <= ErrNone;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      verify_q   <= verify_d;
      word_q     <= word_d;
      data_q     <= data_d;
      toggle_q   <= toggle_d;
      tmr_q      <= tmr_d;
      error_q    <= error_d;
      err_addr_q <= err_addr_d;
      err_code_q <= err_code_d;
    end
  end

  assign cfg_word        = word_q;
  assign cfg_toggle      = toggle_q;
  assign done            = (state_q == StDone);
  assign error           = error_q;
  assign err_addr        = err_addr_q;
  assign err_code        = err_code_q;
  assign unused_readback = ^cfg_readback[CfgW-1:CfgDataMsb+1];

endmodule

// File: tb/tb_ad9826_init_seq.sv
// Directed bench for ad9826_init_seq with a behavioural AD9826 serial-port driver model.
module tb_ad9826_init_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        verify = 1'b0;
  logic        reg_wr_en = 1'b0;
  logic [2:0]  reg_wr_addr = '0;
  logic [8:0]  reg_wr_data = '0;
  logic [15:0] cfg_word;
  logic        cfg_toggle;
  logic        cfg_sload = 1'b1;
  logic [15:0] cfg_readback = '0;
  logic        busy, done, error;
  logic [2:0]  err_addr;
  logic [1:0]  err_code;

  int n_vec = 0;
  int n_err = 0;

  ad9826_init_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .verify       (verify),
    .reg_wr_en    (reg_wr_en),
    .reg_wr_addr  (reg_wr_addr),
    .reg_wr_data  (reg_wr_data),
    .cfg_word     (cfg_word),
    .cfg_toggle   (cfg_toggle),
    .cfg_sload    (cfg_sload),
    .cfg_readback (cfg_readback),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_addr     (err_addr),
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  // Driver model: samples toggle once per 16 clk, frame holds sload low 256 clk.
  logic        model_en = 1'b1;
  logic [3:0]  bad_addr = 4'hF;
  logic [15:0] frames[$];
  logic [8:0]  echo [8];
  logic [15:0] cur_word = '0;
  int          div_q = 0;
  int          frame_cnt = 0;

  always @(posedge clk) begin
    div_q <= (div_q + 1) % 16;
    if (frame_cnt != 0) begin
      frame_cnt <= frame_cnt - 1;
      if (frame_cnt == 1) begin
        cfg_sload <= 1'b1;
        if (cur_word[15]) begin
          cfg_readback <= {7'd0, ({1'b0, cur_word[14:12]} == bad_addr) ? 9'd0
                                                                       : echo[cur_word[14:12]]};
        end else begin
          echo[cur_word[14:12]] <= cur_word[8:0];
        end
      end
    end else if (model_en && div_q == 0 && cfg_toggle) begin
      cur_word <= cfg_word;
      frames.push_back(cfg_word);
      cfg_sload <= 1'b0;
      frame_cnt <= 256;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [8:0] d);
    step();
    reg_wr_en = 1'b1;
    reg_wr_addr = a;
    reg_wr_data = d;
    step();
    reg_wr_en = 1'b0;
  endtask

  task automatic load_pattern();
    for (int i = 0; i < 8; i++) wr(3'(i), 9'(9'h0A0 + i));
  endtask

  task automatic pulse_start(input logic vfy);
    step();
    start = 1'b1;
    verify = vfy;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output int nd, output int ntgl);
    bit ended;
    ended = 1'b0;
    nd = 0;
    ntgl = 0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (done) nd++;
      if (cfg_toggle) ntgl++;
      if (!busy) begin
        ended = 1'b1;
        break;
      end
    end
    check("seq_end", 32'(ended), 32'd1);
  endtask

  function automatic logic [15:0] wr_word(input int a, input logic [8:0] d);
    return {1'b0, 3'(a), 3'b000, d};
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nd, ntgl, nbusy0, n4, lowcnt;
    bit s2, w;

    // Reset values
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_toggle", 32'(cfg_toggle), 32'd0);
    check("rst_word", 32'(cfg_word), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_err_addr", 32'(err_addr), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Plain write sequence, plus start latency
    load_pattern();
    frames.delete();
    pulse_start(1'b0);
    @(negedge clk);
    check("lat_word_c1", 32'(cfg_word), 32'd0);
    check("lat_tgl_c1", 32'(cfg_toggle), 32'd0);
    @(negedge clk);
    check("lat_word_c2", 32'(cfg_word), 32'h00A0);
    check("lat_tgl_c2", 32'(cfg_toggle), 32'd0);
    @(negedge clk);
    check("lat_tgl_c3", 32'(cfg_toggle), 32'd1);
    wait_idle(4000, nd, ntgl);
    check("wr_nframes", 32'(frames.size()), 32'd8);
    for (int i = 0; i < 8; i++) check("wr_frame", 32'(frames[i]), 32'(wr_word(i, 9'(9'h0A0 + i))));
    check("wr_done", 32'(nd), 32'd1);
    check("wr_error", 32'(error), 32'd0);

    // Verify sequence with echoing model
    frames.delete();
    pulse_start(1'b1);
    wait_idle(8000, nd, ntgl);
    check("vfy_nframes", 32'(frames.size()), 32'd16);
    for (int i = 0; i < 8; i++) begin
      check("vfy_wframe", 32'(frames[2*i]), 32'(wr_word(i, 9'(9'h0A0 + i))));
      check("vfy_rframe", 32'(frames[2*i+1]), 32'({1'b1, 3'(i), 12'h000}));
    end
    check("vfy_done", 32'(nd), 32'd1);
    check("vfy_error", 32'(error), 32'd0);

    // Read-back mismatch at address 3
    bad_addr = 4'd3;
    frames.delete();
    pulse_start(1'b1);
    wait_idle(8000, nd, ntgl);
    n4 = 0;
    foreach (frames[i]) if (frames[i][14:12] == 3'd4) n4++;
    check("mis_error", 32'(error), 32'd1);
    check("mis_code", 32'(err_code), 32'd3);
    check("mis_addr", 32'(err_addr), 32'd3);
    check("mis_nframes", 32'(frames.size()), 32'd8);
    check("mis_addr4_frames", 32'(n4), 32'd0);
    check("mis_done", 32'(nd), 32'd0);
    bad_addr = 4'hF;

    // Driver never responds: request timeout
    model_en = 1'b0;
    frames.delete();
    pulse_start(1'b0);
    wait_idle(400, nd, ntgl);
    check("to_toggle_cycles", 32'(ntgl), 32'd64);
    check("to_error", 32'(error), 32'd1);
    check("to_code", 32'(err_code), 32'd1);
    check("to_addr", 32'(err_addr), 32'd0);
    check("to_nframes", 32'(frames.size()), 32'd0);
    model_en = 1'b1;

    // Reset mid-frame, start straight after release
    frames.delete();
    pulse_start(1'b0);
    lowcnt = 0;
    for (int c = 0; c < 2000 && !(frames.size() == 2 && !cfg_sload); c++) @(negedge clk);
    check("mr_reached_frame", 32'(frames.size()), 32'd2);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    verify = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("mr_busy_after_rst", 32'(busy), 32'd1);
    nbusy0 = 0;
    ntgl = 0;
    for (int c = 0; c < 400 && !cfg_sload; c++) begin
      @(negedge clk);
      if (!busy && !cfg_sload) nbusy0++;
      if (cfg_toggle) ntgl++;
    end
    check("mr_busy_held", 32'(nbusy0), 32'd0);
    check("mr_no_toggle", 32'(ntgl), 32'd0);
    repeat (40) @(negedge clk);
    check("mr_start_ignored", 32'(frames.size()), 32'd2);
    check("mr_idle", 32'(busy), 32'd0);
    frames.delete();
    pulse_start(1'b0);
    wait_idle(4000, nd, ntgl);
    check("mr_nframes", 32'(frames.size()), 32'd8);
    for (int i = 0; i < 8; i++) check("mr_frame", 32'(frames[i]), 32'(wr_word(i, 9'h000)));
    check("mr_done", 32'(nd), 32'd1);

    // Second start mid-sequence and shadow write during addr 2 transfer
    load_pattern();
    frames.delete();
    pulse_start(1'b0);
    s2 = 1'b0;
    w = 1'b0;
    nd = 0;
    lowcnt = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      start = 1'b0;
      reg_wr_en = 1'b0;
      if (done) nd++;
      if (!busy) break;
      if (frames.size() == 1 && !s2) begin
        start = 1'b1;
        s2 = 1'b1;
      end
      if (frames.size() == 3 && !cfg_sload) lowcnt++;
      if (lowcnt == 10 && !w) begin
        reg_wr_en = 1'b1;
        reg_wr_addr = 3'd0;
        reg_wr_data = 9'h155;
        w = 1'b1;
      end
    end
    start = 1'b0;
    reg_wr_en = 1'b0;
    check("ds_nframes", 32'(frames.size()), 32'd8);
    check("ds_frame0", 32'(frames[0]), 32'h00A0);
    check("ds_frame7", 32'(frames[7]), 32'h70A7);
    check("ds_done", 32'(nd), 32'd1);
    frames.delete();
    pulse_start(1'b0);
    wait_idle(4000, nd, ntgl);
    check("ds_next_frame0", 32'(frames[0]), 32'h0155);
    check("ds_next_frame1", 32'(frames[1]), 32'h10A1);
    check("ds_next_done", 32'(nd), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
